// File: rtl/lcd_pkg.sv
// lcd_pkg: shared constants, state types and character helpers for the
// HD44780 result writer (lcd_result_writer and its byte-transfer engine).
package lcd_pkg;

  // HD44780 command bytes and the separator character
  localparam logic [7:0] FUNC_SET = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
  localparam logic [7:0] DISP_ON  = 8'h0C;  // display on, cursor off
  localparam logic [7:0] ENTRY    = 8'h06;  // increment, no shift
  localparam logic [7:0] CLEAR    = 8'h01;  // clear display (slow command)
  localparam logic [7:0] LINE1    = 8'h80;  // DDRAM address 0
  localparam logic [7:0] SPACE    = 8'h20;

  // Byte counts of the two sequences
  localparam logic [2:0] INIT_LEN  = 3'd4;
  localparam logic [2:0] WRITE_LEN = 3'd5;

  // Top-level sequencer states
  typedef enum logic [1:0] {
    ST_POWERUP = 2'd0,
    ST_INIT    = 2'd1,
    ST_IDLE    = 2'd2,
    ST_WRITE   = 2'd3
  } lcd_state_e;

  // Byte-transfer engine phases
  typedef enum logic [1:0] {
    PH_IDLE  = 2'd0,
    PH_SETUP = 2'd1,
    PH_EN    = 2'd2,
    PH_WAIT  = 2'd3
  } xfer_phase_e;

  // Upper-case hex digit to ASCII
  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    if (n < 4'd10) begin
      return 8'h30 + {4'h0, n};
    end else begin
      return 8'h37 + {4'h0, n};
    end
  endfunction

  // Init command for sequence position idx
  function automatic logic [7:0] init_cmd(input logic [2:0] idx);
    case (idx)
      3'd0:    return FUNC_SET;
      3'd1:    return DISP_ON;
      3'd2:    return ENTRY;
      3'd3:    return CLEAR;
      default: return FUNC_SET;
    endcase
  endfunction

  // Data character for write position idx (position 0 is the LINE1 command)
  function automatic logic [7:0] write_char(input logic [2:0] idx,
                                            input logic [3:0] sel,
                                            input logic [7:0] value);
    case (idx)
      3'd1:    return hex_ascii(sel);
      3'd2:    return SPACE;
      3'd3:    return hex_ascii(value[7:4]);
      3'd4:    return hex_ascii(value[3:0]);
      default: return SPACE;
    endcase
  endfunction

endpackage

// File: rtl/lcd_byte_xfer.sv
// lcd_byte_xfer: drives one HD44780 byte write per go request.
//   A byte is one setup cycle (rs/data driven, en low), EN_CYCLES cycles with
//   en high, then WAIT_CYCLES (or CLEAR_WAIT_CYCLES when long_wait) en low.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   go            start a byte; honoured only while ready
//   rs, tx_byte   register select and byte for the transfer
//   long_wait     use CLEAR_WAIT_CYCLES for the trailing wait
//   ready         high when idle
//   lcd_rs, lcd_en, lcd_data  registered LCD bus
// The idle phase doubles as the final wait cycle: rs/data are held while idle,
// so a go issued on that cycle gives back-to-back bytes with no gap.
// Requires WAIT_CYCLES >= 2 and CLEAR_WAIT_CYCLES >= 2.
module lcd_byte_xfer
  import lcd_pkg::*;
#(
  parameter int EN_CYCLES         = 25,
  parameter int WAIT_CYCLES       = 2500,
  parameter int CLEAR_WAIT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       go,
  input  logic       rs,
  input  logic [7:0] tx_byte,
  input  logic       long_wait,
  output logic       ready,
  output logic       lcd_rs,
  output logic       lcd_en,
  output logic [7:0] lcd_data
);

  localparam logic [31:0] EN_LAST    = 32'(EN_CYCLES - 1);
  localparam logic [31:0] WAIT_LAST  = 32'(WAIT_CYCLES - 2);
  localparam logic [31:0] CLEAR_LAST = 32'(CLEAR_WAIT_CYCLES - 2);

  xfer_phase_e phase_r, phase_s;
  logic [31:0] cnt_r, cnt_s;
  logic        en_r, en_s;
  logic        rs_r, rs_s;
  logic [7:0]  data_r, data_s;
  logic        long_r, long_s;
  logic [31:0] wait_last_s;

  assign ready    = (phase_r == PH_IDLE);
  assign lcd_rs   = rs_r;
  assign lcd_en   = en_r;
  assign lcd_data = data_r;

  // Phase sequencing and bus register next-values
  always_comb begin
    phase_s     = phase_r;
    cnt_s       = cnt_r;
    en_s        = en_r;
    rs_s        = rs_r;
    data_s      = data_r;
    long_s      = long_r;
    wait_last_s = long_r ? CLEAR_LAST : WAIT_LAST;
    case (phase_r)
      PH_IDLE: begin
        if (go) begin
          rs_s    = rs;
          data_s  = tx_byte;
          long_s  = long_wait;
          phase_s = PH_SETUP;
        end else begin
          phase_s = PH_IDLE;
        end
      end
      PH_SETUP: begin
        en_s    = 1'b1;
        cnt_s   = 32'd0;
        phase_s = PH_EN;
      end
      PH_EN: begin
        if (cnt_r == EN_LAST) begin
          en_s    = 1'b0;
          cnt_s   = 32'd0;
          phase_s = PH_WAIT;
        end else begin
          cnt_s = cnt_r + 32'd1;
        end
      end
      PH_WAIT: begin
        // One wait cycle is spent back in PH_IDLE, hence the "-2" limits
        if (cnt_r == wait_last_s) begin
          cnt_s   = 32'd0;
          phase_s = PH_IDLE;
        end else begin
          cnt_s = cnt_r + 32'd1;
        end
      end
      default: begin
        en_s    = 1'b0;
        phase_s = PH_IDLE;
      end
    endcase
  end

  // State and bus registers
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_r <= PH_IDLE;
      cnt_r   <= 32'd0;
      en_r    <= 1'b0;
      rs_r    <= 1'b0;
      data_r  <= 8'h00;
      long_r  <= 1'b0;
    end else begin
      phase_r <= phase_s;
      cnt_r   <= cnt_s;
      en_r    <= en_s;
      rs_r    <= rs_s;
      data_r  <= data_s;
      long_r  <= long_s;
    end
  end

endmodule

// File: rtl/lcd_result_writer_checker.sv
// lcd_result_writer_checker: bus-protocol assertions for the LCD interface.
//   lcd_rs/lcd_data must hold while lcd_en is high (including the rising
//   cycle, which must match the setup cycle), and lcd_rw is always 0.
// Ports: clk, rst and the observed LCD bus signals (all inputs).
module lcd_result_writer_checker (
  input logic       clk,
  input logic       rst,
  input logic       lcd_en,
  input logic       lcd_rs,
  input logic       lcd_rw,
  input logic [7:0] lcd_data
);

  logic       prev_ok_r;
  logic       prev_rs_r;
  logic [7:0] prev_data_r;

  // Previous-cycle bus snapshot
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_ok_r   <= 1'b0;
      prev_rs_r   <= 1'b0;
      prev_data_r <= 8'h00;
    end else begin
      prev_ok_r   <= 1'b1;
      prev_rs_r   <= lcd_rs;
      prev_data_r <= lcd_data;
    end
  end

  // Protocol assertions
  always @(posedge clk) begin
    if (!rst && prev_ok_r && lcd_en) begin
      assert (lcd_data == prev_data_r && lcd_rs == prev_rs_r)
        else $error("FAIL checker_stable: rs/data changed while lcd_en high");
    end
    assert (lcd_rw == 1'b0)
      else $error("FAIL checker_rw: lcd_rw is %b, must be 0", lcd_rw);
  end

endmodule

// File: rtl/lcd_result_writer.sv
// lcd_result_writer: initialises an HD44780 in 8-bit mode and, on request,
// writes "<sel> <value>" as hex characters at the start of line 1.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   start          display request, sampled only in IDLE
//   sel, value     opcode and result to display (latched on start)
//   busy           high whenever not in IDLE
//   done           one-cycle pulse when an update completes
//   lcd_rs/rw/en/data  HD44780 bus (rw tied low)
// Each sequence's first byte is issued on the cycle that enters the sequence
// (last POWERUP cycle, or the IDLE cycle that sees start), so its setup cycle
// is the first cycle of INIT/WRITE.
module lcd_result_writer
  import lcd_pkg::*;
#(
  parameter int POWERUP_CYCLES    = 750000,
  parameter int EN_CYCLES         = 25,
  parameter int WAIT_CYCLES       = 2500,
  parameter int CLEAR_WAIT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] sel,
  input  logic [7:0] value,
  output logic       busy,
  output logic       done,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_en,
  output logic [7:0] lcd_data
);

  localparam logic [31:0] PU_LAST = 32'(POWERUP_CYCLES - 1);

  lcd_state_e  state_r, state_s;
  logic [31:0] pcnt_r, pcnt_s;
  logic [2:0]  idx_r, idx_s;    // bytes issued so far in the current sequence
  logic [3:0]  sel_r, sel_s;
  logic [7:0]  value_r, value_s;
  logic        done_r, done_s;
  logic        go_s, rs_s, long_s, ready_s;
  logic [7:0]  byte_s;

  assign busy   = (state_r != ST_IDLE);
  assign done   = done_r;
  assign lcd_rw = 1'b0;

  lcd_byte_xfer #(
    .EN_CYCLES        (EN_CYCLES),
    .WAIT_CYCLES      (WAIT_CYCLES),
    .CLEAR_WAIT_CYCLES(CLEAR_WAIT_CYCLES)
  ) u_xfer (
    .clk      (clk),
    .rst      (rst),
    .go       (go_s),
    .rs       (rs_s),
    .tx_byte  (byte_s),
    .long_wait(long_s),
    .ready    (ready_s),
    .lcd_rs   (lcd_rs),
    .lcd_en   (lcd_en),
    .lcd_data (lcd_data)
  );

  // Sequencer next-state, byte selection and done generation
  always_comb begin
    state_s = state_r;
    pcnt_s  = pcnt_r;
    idx_s   = idx_r;
    sel_s   = sel_r;
    value_s = value_r;
    done_s  = 1'b0;
    go_s    = 1'b0;
    rs_s    = 1'b0;
    long_s  = 1'b0;
    byte_s  = 8'h00;
    case (state_r)
      ST_POWERUP: begin
        if (pcnt_r == PU_LAST) begin
          go_s    = 1'b1;
          byte_s  = init_cmd(3'd0);
          idx_s   = 3'd1;
          pcnt_s  = 32'd0;
          state_s = ST_INIT;
        end else begin
          pcnt_s = pcnt_r + 32'd1;
        end
      end
      ST_INIT: begin
        if (ready_s) begin
          if (idx_r == INIT_LEN) begin
            idx_s   = 3'd0;
            state_s = ST_IDLE;
          end else begin
            go_s   = 1'b1;
            byte_s = init_cmd(idx_r);
            long_s = (init_cmd(idx_r) == CLEAR);
            idx_s  = idx_r + 3'd1;
          end
        end else begin
          state_s = ST_INIT;
        end
      end
      ST_IDLE: begin
        if (start && ready_s) begin
          sel_s   = sel;
          value_s = value;
          go_s    = 1'b1;
          byte_s  = LINE1;
          idx_s   = 3'd1;
          state_s = ST_WRITE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WRITE: begin
        if (ready_s) begin
          if (idx_r == WRITE_LEN) begin
            done_s  = 1'b1;
            idx_s   = 3'd0;
            state_s = ST_IDLE;
          end else begin
            go_s   = 1'b1;
            rs_s   = 1'b1;
            byte_s = write_char(idx_r, sel_r, value_r);
            idx_s  = idx_r + 3'd1;
          end
        end else begin
          state_s = ST_WRITE;
        end
      end
      default: begin
        pcnt_s  = 32'd0;
        idx_s   = 3'd0;
        state_s = ST_POWERUP;
      end
    endcase
  end

  // Sequencer state, latched operands and done pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_POWERUP;
      pcnt_r  <= 32'd0;
      idx_r   <= 3'd0;
      sel_r   <= 4'h0;
      value_r <= 8'h00;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      pcnt_r  <= pcnt_s;
      idx_r   <= idx_s;
      sel_r   <= sel_s;
      value_r <= value_s;
      done_r  <= done_s;
    end
  end

endmodule

// File: tb/tb_lcd_result_writer.sv
// tb_lcd_result_writer: self-checking bench for lcd_result_writer.
// The reference model turns a list of bytes into the expected per-cycle bus
// trace (setup, enable, wait) and compares every cycle of every sequence.
module tb_lcd_result_writer;

  localparam int PU = 5;
  localparam int EN = 2;
  localparam int WT = 3;
  localparam int CW = 6;
  localparam int WRITE_CYC = 5 * (1 + EN + WT);

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] sel = 4'h0;
  logic [7:0] value = 8'h00;
  logic       busy, done, lcd_rs, lcd_rw, lcd_en;
  logic [7:0] lcd_data;

  int tests = 0;
  int fails = 0;

  // expected per-cycle trace: {en, rs, data}
  logic [9:0] q_bus[$];

  always #5 clk = ~clk;

  lcd_result_writer #(
    .POWERUP_CYCLES(PU), .EN_CYCLES(EN), .WAIT_CYCLES(WT), .CLEAR_WAIT_CYCLES(CW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .sel(sel), .value(value),
    .busy(busy), .done(done), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
    .lcd_en(lcd_en), .lcd_data(lcd_data)
  );

  lcd_result_writer_checker u_chk (
    .clk(clk), .rst(rst), .lcd_en(lcd_en), .lcd_rs(lcd_rs),
    .lcd_rw(lcd_rw), .lcd_data(lcd_data)
  );

  function automatic logic [7:0] ascii_hex(input int n);
    if (n < 10) return 8'(48 + n);
    else return 8'(65 + n - 10);
  endfunction

  // model: one byte = 1 setup cycle, EN high cycles, 'low' wait cycles
  task automatic push_byte(input logic rs, input logic [7:0] b, input int low);
    q_bus.push_back({1'b0, rs, b});
    for (int i = 0; i < EN; i++) q_bus.push_back({1'b1, rs, b});
    for (int i = 0; i < low; i++) q_bus.push_back({1'b0, rs, b});
  endtask

  task automatic push_write(input logic [3:0] s, input logic [7:0] v);
    push_byte(1'b0, 8'h80, WT);
    push_byte(1'b1, ascii_hex(int'(s)), WT);
    push_byte(1'b1, 8'h20, WT);
    push_byte(1'b1, ascii_hex(int'(v) / 16), WT);
    push_byte(1'b1, ascii_hex(int'(v) % 16), WT);
  endtask

  task automatic test_reset();
    logic [12:0] obs;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    obs = {busy, done, lcd_en, lcd_rs, lcd_rw, lcd_data};
    tests++;
    if (obs !== 13'b1_0_0_0_0_00000000) begin
      fails++;
      $display("FAIL reset_state: busy/done/en/rs/rw/data=%b required 1000000000000", obs);
    end
  endtask

  // releases reset and follows the power-up wait and init sequence
  task automatic test_init(input string name);
    logic [11:0] obs;
    logic [11:0] exp;
    q_bus.delete();
    push_byte(1'b0, 8'h38, WT);
    push_byte(1'b0, 8'h0C, WT);
    push_byte(1'b0, 8'h06, WT);
    push_byte(1'b0, 8'h01, CW);
    rst = 1'b0;
    for (int k = 0; k < PU; k++) begin
      obs = {busy, done, lcd_en, lcd_rs, lcd_data};
      tests++;
      if (obs !== 12'b1_0_0_0_00000000) begin
        fails++;
        $display("FAIL %s_powerup cycle %0d: got %h required %h", name, k, obs, 12'h800);
      end
      @(negedge clk);
    end
    for (int k = 0; k < q_bus.size(); k++) begin
      obs = {busy, done, lcd_en, lcd_rs, lcd_data};
      exp = {2'b10, q_bus[k]};
      tests++;
      if (obs !== exp || lcd_rw !== 1'b0) begin
        fails++;
        $display("FAIL %s_trace cycle %0d: busy/done/en/rs/data got %h required %h", name, k, obs, exp);
      end
      @(negedge clk);
    end
    tests++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL %s_idle: busy/done got %b%b required 00", name, busy, done);
    end
  endtask

  // one display update; 'disturb' re-pulses start and alters inputs mid-write
  task automatic test_write(input string name, input logic [3:0] s,
                            input logic [7:0] v, input bit disturb);
    logic [11:0] obs;
    logic [11:0] exp;
    q_bus.delete();
    push_write(s, v);
    start = 1'b1; sel = s; value = v;
    @(negedge clk);
    for (int k = 0; k < WRITE_CYC; k++) begin
      obs = {busy, done, lcd_en, lcd_rs, lcd_data};
      exp = {2'b10, q_bus[k]};
      tests++;
      if (obs !== exp) begin
        fails++;
        $display("FAIL %s cycle %0d: busy/done/en/rs/data got %h required %h", name, k, obs, exp);
      end
      if (k == 0) begin
        start = 1'b0;
        sel = 4'($urandom);
        value = 8'($urandom);
      end
      if (disturb && k == 7) start = 1'b1;
      if (disturb && k == 8) start = 1'b0;
      if (disturb && k == 14) begin
        value = ~v;
        sel = ~s;
      end
      @(negedge clk);
    end
    tests++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL %s_done: busy/done got %b%b required 01", name, busy, done);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      tests++;
      if (done !== 1'b0 || busy !== 1'b0 || lcd_en !== 1'b0) begin
        fails++;
        $display("FAIL %s_after %0d: busy/done/en got %b%b%b required 000", name, k, busy, done, lcd_en);
      end
    end
  endtask

  // start held high: a second update begins on the IDLE cycle of the first's done
  task automatic test_back_to_back();
    logic [11:0] obs;
    logic [11:0] exp;
    logic [3:0]  s[2];
    logic [7:0]  v[2];
    for (int u = 0; u < 2; u++) begin
      s[u] = 4'($urandom);
      v[u] = 8'($urandom);
    end
    start = 1'b1; sel = s[0]; value = v[0];
    @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      q_bus.delete();
      push_write(s[u], v[u]);
      for (int k = 0; k < WRITE_CYC; k++) begin
        obs = {busy, done, lcd_en, lcd_rs, lcd_data};
        exp = {2'b10, q_bus[k]};
        tests++;
        if (obs !== exp) begin
          fails++;
          $display("FAIL b2b_%0d cycle %0d: got %h required %h", u, k, obs, exp);
        end
        if (k == 3) begin
          sel = s[1];
          value = v[1];
        end
        @(negedge clk);
      end
      tests++;
      if (done !== 1'b1 || busy !== 1'b0) begin
        fails++;
        $display("FAIL b2b_%0d_done: busy/done got %b%b required 01", u, busy, done);
      end
      if (u == 1) start = 1'b0;
      @(negedge clk);
    end
    tests++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL b2b_end: busy/done got %b%b required 00", busy, done);
    end
  endtask

  // reset while en is high during WRITE, then full re-initialisation
  task automatic test_reset_mid();
    start = 1'b1; sel = 4'($urandom); value = 8'($urandom);
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);   // second byte, first enable cycle
    tests++;
    if (lcd_en !== 1'b1) begin
      fails++;
      $display("FAIL rst_mid_en_pre: lcd_en got %b required 1", lcd_en);
    end
    rst = 1'b1;
    @(negedge clk);
    tests++;
    if (lcd_en !== 1'b0 || done !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL rst_mid_drop: en/done/busy got %b%b%b required 001", lcd_en, done, busy);
    end
    @(negedge clk);
    tests++;
    if ({busy, done, lcd_en, lcd_rs, lcd_rw, lcd_data} !== 13'b1_0_0_0_0_00000000) begin
      fails++;
      $display("FAIL rst_mid_state: got %b required 1000000000000",
               {busy, done, lcd_en, lcd_rs, lcd_rw, lcd_data});
    end
    test_init("reinit");
  endtask

  initial begin
    test_reset();
    test_init("init");
    test_write("write_2_3c", 4'h2, 8'h3C, 1'b0);
    test_write("write_8_af", 4'h8, 8'hAF, 1'b0);
    test_write("write_f_09", 4'hF, 8'h09, 1'b0);
    test_write("write_ignore", 4'hA, 8'h5B, 1'b1);
    for (int i = 0; i < 4; i++) begin
      test_write("write_rand", 4'($urandom), 8'($urandom), 1'b0);
    end
    test_back_to_back();
    test_reset_mid();
    test_write("write_after_reinit", 4'h0, 8'hF0, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lcd_result_writer.md
LCD_RESULT_WRITER -- requirements
Module: lcd_result_writer

Interface
REQ-001 Parameter POWERUP_CYCLES, default 750000, idle cycles after reset before the first init command (15 ms at 50 MHz).
REQ-002 Parameter EN_CYCLES, default 25, cycles lcd_en is held high per byte.
REQ-003 Parameter WAIT_CYCLES, default 2500, cycles lcd_en is held low after each byte.
REQ-004 Parameter CLEAR_WAIT_CYCLES, default 100000, replaces WAIT_CYCLES after the clear-display command.
REQ-005 clk  input  1  single system clock; all logic is on its rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 start  input  1  request to display the current sel/value; sampled only in IDLE.
REQ-008 sel  input  4  logic-unit opcode to display.
REQ-009 value  input  8  logic-unit result to display.
REQ-010 busy  output  1  high whenever the FSM is not in IDLE.
REQ-011 done  output  1  one-cycle pulse when a display update completes.
REQ-012 lcd_rs  output  1  HD44780 register select: 0 = command, 1 = data.
REQ-013 lcd_rw  output  1  tied 0 (write only).
REQ-014 lcd_en  output  1  HD44780 enable strobe.
REQ-015 lcd_data  output  8  HD44780 8-bit data bus.

Function
REQ-016 The top FSM SHALL have the states POWERUP, INIT, IDLE, and WRITE.
REQ-017 POWERUP SHALL count POWERUP_CYCLES cycles and then enter INIT.
REQ-018 INIT SHALL send the commands 0x38, 0x0C, 0x06, 0x01 in that order and then enter IDLE.
REQ-019 Each byte transfer SHALL take 1 setup cycle (lcd_rs and lcd_data driven, lcd_en=0), then EN_CYCLES cycles with lcd_en=1, then WAIT_CYCLES cycles (or CLEAR_WAIT_CYCLES after 0x01) with lcd_en=0.
REQ-020 lcd_rs and lcd_data SHALL remain stable from the setup cycle through the end of that transfer's wait.
REQ-021 When start=1 in IDLE, sel and value SHALL be latched in that cycle and the FSM SHALL enter WRITE on the next cycle.
REQ-022 WRITE SHALL send, in order: command 0x80, then data ASCII(hex sel), 0x20, ASCII(hex value[7:4]), ASCII(hex value[3:0]).
REQ-023 Hex-to-ASCII conversion SHALL map 0-9 to 0x30-0x39 and A-F to 0x41-0x46 (upper case).
REQ-024 After the last WRITE byte's wait, done SHALL pulse for 1 cycle, coincident with the return to IDLE and busy falling.
REQ-025 start while busy=1 SHALL be ignored, neither queued nor latched.
REQ-026 Changes on sel or value during WRITE SHALL not affect the displayed characters.
REQ-027 start held continuously high SHALL trigger a new update on each IDLE entry.

Reset
REQ-028 While rst=1: the FSM SHALL be in POWERUP, counters 0, busy=1, done=0, lcd_en=0, lcd_rs=0, lcd_rw=0, lcd_data=0x00, and the latched sel/value 0.
REQ-029 Reset asserted mid-transfer SHALL drop lcd_en in the next cycle, abandon the update without a done pulse, and rerun POWERUP plus INIT.

Structure
REQ-030 Package lcd_pkg SHALL hold the command constants (FUNC_SET 0x38, DISP_ON 0x0C, ENTRY 0x06, CLEAR 0x01, LINE1 0x80), the FSM state type, and the hex-to-ASCII function.
REQ-031 One sub-module, lcd_byte_xfer, SHALL implement REQ-019 with the handshake go/rs/byte/long_wait in and ready out, where ready is high when idle.
REQ-032 The top level SHALL sequence bytes through lcd_byte_xfer only.

Verification
REQ-033 All scenarios SHALL use POWERUP_CYCLES=5, EN_CYCLES=2, WAIT_CYCLES=3, CLEAR_WAIT_CYCLES=6, so a normal byte takes 6 cycles and a clear takes 9.
REQ-034 Release reset -> 5 idle cycles, then bytes 38, 0C, 06 (rs=0) each with en high 2 cycles, 01 followed by 6 low cycles, then busy=0.
REQ-035 In IDLE, start with sel=4'h2 and value=8'h3C -> bytes 80 (rs=0), then 32, 20, 33, 43 (rs=1); done 1 cycle after 30 WRITE cycles.
REQ-036 value=8'hAF with sel=4'h8 -> data bytes 38, 20, 41, 46.
REQ-037 start pulsed during the 2nd WRITE byte, and value changed mid-WRITE -> no second update; the originally latched characters are displayed.
REQ-038 rst asserted while lcd_en=1 during WRITE -> lcd_en=0 next cycle, no done pulse, full init sequence repeats.
REQ-039 Checker: lcd_data/lcd_rs never change while lcd_en=1, and lcd_rw=0 always.
